// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: FSM state encoding,
// default bus widths, default timeout and a counter-width helper.
// Optional feature macro used by the bridge: DMEM_TIMEOUT_EN.
package dmem_bridge_pkg;

  localparam int unsigned ADDR_W_DEF         = 64;
  localparam int unsigned DATA_W_DEF         = 64;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Bits needed to hold values 0..limit
  function automatic int unsigned ctr_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Per-access bus timeout counter.
// Ports:
//   clk, rst       clock, async active-low reset
//   clr            restart counting (new access launched)
//   inc            access is waiting on the bus this cycle
//   expire_c       this waiting cycle is the last one allowed (combinational)
module dmem_timeout_ctr
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire_c
);

  localparam int unsigned CNT_W = ctr_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;

  // Saturating count of waiting cycles since the access was launched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // count_q holds the number of waiting cycles already elapsed, so the
  // TIMEOUT_CYCLES-th waiting cycle is the one where count_q == LAST.
  assign expire_c = inc && (count_q >= LAST);

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge between the single-cycle core memory port and a
// valid/ready request + response memory bus. Stalls the core for the
// duration of each access and presents load data in the DONE cycle.
// Optional feature: define DMEM_TIMEOUT_EN to abort accesses that wait
// TIMEOUT_CYCLES bus cycles (mem_err pulses in the aborted DONE cycle).
// Ports:
//   clk, rst                      clock, async active-low reset
//   mem_read, mem_write           core load/store request (write wins)
//   mem_addr, mem_wdata           core address / store data
//   mem_rdata                     load data (0 for stores and aborts)
//   stall                         hold PC and register-file write
//   mem_err                       one-cycle timeout abort pulse
//   bus_req_valid/bus_req_ready   request handshake
//   bus_we, bus_addr, bus_wdata   registered request fields
//   bus_rsp_valid, bus_rdata      response / read data
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              mem_err,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_rsp_valid,
  input  logic [DATA_W-1:0] bus_rdata
);

  state_e state_q, state_d;

  logic              req_c;
  logic              handshake_c;
  logic              abort_c;
  logic              accept_c;
  logic              release_c;
  logic              capture_c;

  logic              valid_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  // A request is never taken while reset is asserted, so stall stays low
  assign req_c       = rst & (mem_read | mem_write);
  assign handshake_c = valid_q & bus_req_ready;

`ifdef DMEM_TIMEOUT_EN
  logic ctr_clr_c;
  logic ctr_inc_c;
  logic err_q;

  assign ctr_clr_c = (state_q == ST_IDLE) && req_c;
  assign ctr_inc_c = (state_q == ST_REQ) || (state_q == ST_RESP);

  dmem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr      (ctr_clr_c),
    .inc      (ctr_inc_c),
    .expire_c (abort_c)
  );

  // Error flag is high exactly in the DONE cycle that follows an abort
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= abort_c;
    end
  end

  assign mem_err = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign abort_c        = 1'b0;
  assign mem_err        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an abort takes priority over bus progress
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_c)                    state_d = ST_REQ;
      ST_REQ:  if (abort_c)                  state_d = ST_DONE;
               else if (handshake_c)         state_d = ST_RESP;
      ST_RESP: if (abort_c || bus_rsp_valid) state_d = ST_DONE;
      ST_DONE:                               state_d = ST_IDLE;
      default:                               state_d = ST_IDLE;
    endcase
  end

  // Output decode: stall plus the datapath load strobes
  always_comb begin
    stall     = 1'b0;
    accept_c  = 1'b0;
    release_c = 1'b0;
    capture_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stall    = req_c;
        accept_c = req_c;
      end
      ST_REQ: begin
        stall     = 1'b1;
        release_c = handshake_c | abort_c;
        capture_c = abort_c;
      end
      ST_RESP: begin
        stall     = 1'b1;
        capture_c = bus_rsp_valid | abort_c;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  // Request registers and load-data capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept_c) begin
        valid_q <= 1'b1;
        we_q    <= mem_write;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end else if (release_c) begin
        valid_q <= 1'b0;
      end
      // Stores and aborted accesses return zero load data
      if (capture_c) begin
        rdata_q <= (we_q || abort_c) ? '0 : bus_rdata;
      end
    end
  end

  assign bus_req_valid = valid_q;
  assign bus_we        = we_q;
  assign bus_addr      = addr_q;
  assign bus_wdata     = wdata_q;
  assign mem_rdata     = rdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed scenarios plus randomized
// accesses against a transaction-level model of stall length, load data,
// request count and timeout behaviour.
module tb_dmem_bridge;

`ifdef DMEM_TIMEOUT_EN
  localparam bit TO_EN      = 1'b1;
  localparam int TB_TIMEOUT = 5;
`else
  localparam bit TO_EN      = 1'b0;
  localparam int TB_TIMEOUT = 255;
`endif

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        stall;
  logic        mem_err;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic        bus_rsp_valid;
  logic [63:0] bus_rdata;

  int n_cmp;
  int n_bad;

  dmem_bridge #(
    .ADDR_W(64),
    .DATA_W(64),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .stall         (stall),
    .mem_err       (mem_err),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rdata     (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Transaction-level expectation: the access spends rw not-ready cycles
  // plus one accepting cycle in the request phase, then sw idle cycles plus
  // one response cycle. With the timeout built in, the access is abandoned
  // if it is still waiting in its TB_TIMEOUT-th waiting cycle.
  function automatic void model(input bit wr, input logic [63:0] rdata,
                                input int rw, input int sw,
                                output int exp_stall, output int exp_hs,
                                output int exp_err, output logic [63:0] exp_rdata);
    bit to;
    to        = TO_EN && (rw + sw + 2 >= TB_TIMEOUT);
    exp_stall = to ? TB_TIMEOUT + 1 : rw + sw + 3;
    exp_hs    = (!to || (rw + 1 <= TB_TIMEOUT)) ? 1 : 0;
    exp_err   = to ? 1 : 0;
    exp_rdata = (to || wr) ? 64'd0 : rdata;
  endfunction

  // Plays the core and the bus slave for one access, ending in the first
  // non-stalled cycle; returns what was observed.
  task automatic do_access(input bit rd, input bit wr,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input logic [63:0] rdata, input int rw, input int sw,
                           output int stall_cycles, output int hs_count,
                           output int field_errs, output int err_pulses,
                           output int first_valid, output bit done_seen,
                           output logic [63:0] done_rdata, output logic done_valid);
    int rwl;
    int swl;
    bit hs_done;
    bit rsp_given;
    stall_cycles = 0;
    hs_count     = 0;
    field_errs   = 0;
    err_pulses   = 0;
    first_valid  = -1;
    done_seen    = 1'b0;
    done_rdata   = 64'd0;
    done_valid   = 1'b0;
    rwl          = rw;
    swl          = sw;
    hs_done      = 1'b0;
    rsp_given    = 1'b0;
    for (int c = 0; c < 200 && !done_seen; c++) begin
      @(negedge clk);
      if (c == 0) begin
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = wdata;
      end
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
      bus_rdata     = rand64();
      if (bus_req_valid) begin
        if (first_valid < 0) first_valid = c;
        if (bus_addr !== addr || bus_we !== wr || bus_wdata !== wdata) field_errs++;
        if (rwl == 0) bus_req_ready = 1'b1;
        else begin
          rwl--;
          bus_rsp_valid = 1'($urandom());
        end
      end else if (hs_done && !rsp_given) begin
        if (swl == 0) begin
          bus_rsp_valid = 1'b1;
          bus_rdata     = rdata;
          rsp_given     = 1'b1;
        end else swl--;
      end
      #1;
      if (mem_err === 1'b1) err_pulses++;
      if (bus_req_valid === 1'b1 && bus_req_ready === 1'b1) begin
        hs_count++;
        hs_done = 1'b1;
      end
      if (stall === 1'b1) stall_cycles++;
      else begin
        done_seen  = 1'b1;
        done_rdata = mem_rdata;
        done_valid = bus_req_valid;
      end
    end
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_addr      = 64'd0;
    mem_wdata     = 64'd0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rdata     = 64'd0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (mem_rdata !== 64'd0)     begin n_bad++; $display("FAIL reset_rdata got %0h want 0", mem_rdata); end
    n_cmp++; if (stall !== 1'b0)          begin n_bad++; $display("FAIL reset_stall got %0b want 0", stall); end
    n_cmp++; if (mem_err !== 1'b0)        begin n_bad++; $display("FAIL reset_err got %0b want 0", mem_err); end
    n_cmp++; if (bus_req_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_valid got %0b want 0", bus_req_valid); end
    n_cmp++; if (bus_we !== 1'b0)         begin n_bad++; $display("FAIL reset_we got %0b want 0", bus_we); end
    n_cmp++; if (bus_addr !== 64'd0)      begin n_bad++; $display("FAIL reset_addr got %0h want 0", bus_addr); end
    n_cmp++; if (bus_wdata !== 64'd0)     begin n_bad++; $display("FAIL reset_wdata got %0h want 0", bus_wdata); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if (stall !== 1'b0 || bus_req_valid !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset got stall=%0b valid=%0b want 0/0", stall, bus_req_valid); end
  endtask

  task automatic test_read_zero_wait();
    int st, hs, fe, ep, fv, es, eh, ee;
    bit ds;
    logic [63:0] dr, er;
    logic dv;
    model(1'b0, 64'hDEADBEEF_CAFEF00D, 0, 0, es, eh, ee, er);
    do_access(1'b1, 1'b0, 64'h100, rand64(), 64'hDEADBEEF_CAFEF00D, 0, 0,
              st, hs, fe, ep, fv, ds, dr, dv);
    n_cmp++; if (!ds)      begin n_bad++; $display("FAIL rd0_done got none want done"); end
    n_cmp++; if (st != es) begin n_bad++; $display("FAIL rd0_stall got %0d want %0d", st, es); end
    n_cmp++; if (fe != 0)  begin n_bad++; $display("FAIL rd0_fields got %0d bad cycles want 0", fe); end
    n_cmp++; if (hs != eh) begin n_bad++; $display("FAIL rd0_requests got %0d want %0d", hs, eh); end
    n_cmp++; if (dr !== er) begin n_bad++; $display("FAIL rd0_rdata got %0h want %0h", dr, er); end
    n_cmp++; if (fv != 1)  begin n_bad++; $display("FAIL rd0_valid_cycle got %0d want 1", fv); end
  endtask

  task automatic test_write_backpressure();
    int st, hs, fe, ep, fv, es, eh, ee;
    bit ds;
    logic [63:0] dr, er;
    logic dv;
    model(1'b1, 64'h1234, 4, 0, es, eh, ee, er);
    do_access(1'b0, 1'b1, 64'h8, 64'h55, 64'h1234, 4, 0,
              st, hs, fe, ep, fv, ds, dr, dv);
    n_cmp++; if (st != es) begin n_bad++; $display("FAIL wr_bp_stall got %0d want %0d", st, es); end
    n_cmp++; if (fe != 0)  begin n_bad++; $display("FAIL wr_bp_fields got %0d bad cycles want 0", fe); end
    n_cmp++; if (dr !== er) begin n_bad++; $display("FAIL wr_bp_rdata got %0h want %0h", dr, er); end
    n_cmp++; if (ep != ee) begin n_bad++; $display("FAIL wr_bp_err got %0d want %0d", ep, ee); end
  endtask

  task automatic test_read_write_both();
    int st, hs, fe, ep, fv, es, eh, ee;
    bit ds;
    logic [63:0] dr, er;
    logic dv;
    model(1'b1, 64'hFFFF_0000_AAAA_5555, 1, 1, es, eh, ee, er);
    do_access(1'b1, 1'b1, 64'h20, 64'h77, 64'hFFFF_0000_AAAA_5555, 1, 1,
              st, hs, fe, ep, fv, ds, dr, dv);
    n_cmp++; if (fe != 0)   begin n_bad++; $display("FAIL both_we_fields got %0d bad cycles want 0", fe); end
    n_cmp++; if (dr !== er) begin n_bad++; $display("FAIL both_rdata got %0h want %0h", dr, er); end
    n_cmp++; if (st != es)  begin n_bad++; $display("FAIL both_stall got %0d want %0d", st, es); end
  endtask

  task automatic test_back_to_back();
    int st, hs, fe, ep, fv, es, eh, ee;
    bit ds;
    logic [63:0] dr, er, d0, d1;
    logic dv;
    d0 = rand64() | 64'd1;
    d1 = rand64() | 64'd1;
    model(1'b0, d0, 0, 0, es, eh, ee, er);
    do_access(1'b1, 1'b0, 64'h10, rand64(), d0, 0, 0, st, hs, fe, ep, fv, ds, dr, dv);
    n_cmp++; if (hs != eh)  begin n_bad++; $display("FAIL b2b_first_requests got %0d want %0d", hs, eh); end
    n_cmp++; if (dr !== er) begin n_bad++; $display("FAIL b2b_first_rdata got %0h want %0h", dr, er); end
    n_cmp++; if (dv !== 1'b0) begin n_bad++; $display("FAIL b2b_done_valid got %0b want 0", dv); end
    model(1'b0, d1, 0, 0, es, eh, ee, er);
    do_access(1'b1, 1'b0, 64'h18, rand64(), d1, 0, 0, st, hs, fe, ep, fv, ds, dr, dv);
    n_cmp++; if (fe != 0)   begin n_bad++; $display("FAIL b2b_second_fields got %0d bad cycles want 0", fe); end
    n_cmp++; if (fv != 1)   begin n_bad++; $display("FAIL b2b_second_valid_cycle got %0d want 1", fv); end
    n_cmp++; if (hs != eh)  begin n_bad++; $display("FAIL b2b_second_requests got %0d want %0d", hs, eh); end
    n_cmp++; if (dr !== er) begin n_bad++; $display("FAIL b2b_second_rdata got %0h want %0h", dr, er); end
  endtask

  task automatic test_reset_mid_resp();
    int st, hs, fe, ep, fv, es, eh, ee;
    bit ds;
    logic [63:0] dr, er, d;
    logic dv;
    @(negedge clk);
    mem_read      = 1'b0;
    mem_write     = 1'b1;
    mem_addr      = 64'h40;
    mem_wdata     = rand64() | 64'd1;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    @(negedge clk);
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b1 || bus_we !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre got stall=%0b we=%0b want 1/1", stall, bus_we); end
    #2;
    rst       = 1'b0;
    mem_write = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0)         begin n_bad++; $display("FAIL rstmid_stall got %0b want 0", stall); end
    n_cmp++; if (bus_we !== 1'b0 || bus_req_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_ctrl got we=%0b valid=%0b want 0/0", bus_we, bus_req_valid); end
    n_cmp++; if (bus_addr !== 64'd0 || bus_wdata !== 64'd0) begin n_bad++; $display("FAIL rstmid_fields got %0h/%0h want 0/0", bus_addr, bus_wdata); end
    n_cmp++; if (mem_rdata !== 64'd0 || mem_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_rdata got %0h err=%0b want 0/0", mem_rdata, mem_err); end
    @(negedge clk);
    rst = 1'b1;
    d = rand64();
    model(1'b0, d, 0, 1, es, eh, ee, er);
    do_access(1'b1, 1'b0, 64'h48, rand64(), d, 0, 1, st, hs, fe, ep, fv, ds, dr, dv);
    n_cmp++; if (st != es || hs != eh) begin n_bad++; $display("FAIL rstmid_after got stall=%0d req=%0d want %0d/%0d", st, hs, es, eh); end
    n_cmp++; if (dr !== er) begin n_bad++; $display("FAIL rstmid_after_rdata got %0h want %0h", dr, er); end
  endtask

  task automatic test_random();
    int st, hs, fe, ep, fv, es, eh, ee, rw, sw, op;
    bit ds, rd, wr;
    logic [63:0] dr, er, d, a;
    logic dv;
    for (int i = 0; i < 24; i++) begin
      op = int'($urandom_range(1, 3));
      rd = op[0];
      wr = op[1];
      rw = int'($urandom_range(0, 3));
      sw = int'($urandom_range(0, 3));
      d  = rand64();
      a  = {rand64()} & ~64'h7;
      model(wr, d, rw, sw, es, eh, ee, er);
      do_access(rd, wr, a, rand64(), d, rw, sw, st, hs, fe, ep, fv, ds, dr, dv);
      n_cmp++; if (st != es)  begin n_bad++; $display("FAIL rand%0d_stall got %0d want %0d", i, st, es); end
      n_cmp++; if (hs != eh)  begin n_bad++; $display("FAIL rand%0d_requests got %0d want %0d", i, hs, eh); end
      n_cmp++; if (dr !== er) begin n_bad++; $display("FAIL rand%0d_rdata got %0h want %0h", i, dr, er); end
      n_cmp++; if (fe != 0 || ep != ee) begin n_bad++; $display("FAIL rand%0d_fields_err got %0d/%0d want 0/%0d", i, fe, ep, ee); end
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b0 || bus_req_valid !== 1'b0) begin n_bad++; $display("FAIL rand%0d_idle got stall=%0b valid=%0b want 0/0", i, stall, bus_req_valid); end
      end
    end
  endtask

`ifdef DMEM_TIMEOUT_EN
  task automatic test_timeout();
    int st, hs, fe, ep, fv, es, eh, ee;
    bit ds;
    logic [63:0] dr, er;
    logic dv;
    model(1'b0, 64'hABCD, 1000, 0, es, eh, ee, er);
    do_access(1'b1, 1'b0, 64'h200, rand64(), 64'hABCD, 1000, 0,
              st, hs, fe, ep, fv, ds, dr, dv);
    n_cmp++; if (!ds || st != es) begin n_bad++; $display("FAIL to_stall got done=%0b stall=%0d want 1/%0d", ds, st, es); end
    n_cmp++; if (ep != ee)  begin n_bad++; $display("FAIL to_err_pulses got %0d want %0d", ep, ee); end
    n_cmp++; if (dr !== er) begin n_bad++; $display("FAIL to_rdata got %0h want %0h", dr, er); end
    n_cmp++; if (hs != eh || dv !== 1'b0) begin n_bad++; $display("FAIL to_abandon got req=%0d valid=%0b want %0d/0", hs, dv, eh); end
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    #1;
    n_cmp++; if (mem_err !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL to_after got err=%0b stall=%0b want 0/0", mem_err, stall); end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_read_zero_wait();
    test_write_backpressure();
    test_read_write_both();
    test_back_to_back();
    test_reset_mid_resp();
    test_random();
`ifdef DMEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
